// File: rtl/amiq_fifo_ctrl_sequencer.sv
// FIFO control initiator: sequences the FIFO hard reset and owns the almost-full /
// almost-empty thresholds, updated through a validated valid/ready config port.
module amiq_fifo_ctrl_sequencer #(
    parameter int P             = 4,
    parameter int RST_CYCLES    = 4,
    parameter int DEF_ALM_FULL  = 1,
    parameter int DEF_ALM_EMPTY = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic         cfg_flush,
    input  logic [P-1:0] cfg_alm_full_thresh,
    input  logic [P-1:0] cfg_alm_empty_thresh,
    output logic         cfg_err,
    output logic         busy,
    output logic         fifo_rst_n,
    output logic [P-1:0] alm_full_thresh,
    output logic [P-1:0] alm_empty_thresh
);

    localparam int              CW       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(RST_CYCLES - 1);
    localparam logic [P:0]      LIMIT    = {1'b1, {P{1'b0}}};

    typedef enum logic [1:0] {INIT_RST, IDLE, FLUSH, SETTLE} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] count_reg, count_next;
    logic [P-1:0]  full_reg, full_next;
    logic [P-1:0]  empty_reg, empty_next;
    logic          fifo_rst_reg, fifo_rst_next;
    logic          ready_reg, ready_next;
    logic          err_reg, err_next;
    logic          busy_reg, busy_next;

    logic [P:0]    req_sum;
    logic          req_ok;

    // Sum is one bit wider than the thresholds so 2**P itself is representable.
    assign req_sum = {1'b0, cfg_alm_full_thresh} + {1'b0, cfg_alm_empty_thresh};
    assign req_ok  = (cfg_alm_full_thresh != '0) && (cfg_alm_empty_thresh != '0)
                     && (req_sum <= LIMIT);

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        full_next     = full_reg;
        empty_next    = empty_reg;
        fifo_rst_next = fifo_rst_reg;
        ready_next    = ready_reg;
        err_next      = 1'b0;

        case (state_reg)
            INIT_RST, FLUSH: begin
                if (count_reg == CNT_LAST) begin
                    count_next    = '0;
                    fifo_rst_next = 1'b1;
                    if (state_reg == INIT_RST) begin
                        state_next = IDLE;
                        ready_next = 1'b1;
                    end else begin
                        state_next = SETTLE;
                    end
                end else begin
                    count_next = count_reg + CW'(1);
                end
            end
            IDLE: begin
                if (cfg_valid && ready_reg) begin
                    ready_next = 1'b0;
                    state_next = SETTLE;
                    if (req_ok) begin
                        full_next  = cfg_alm_full_thresh;
                        empty_next = cfg_alm_empty_thresh;
                        if (cfg_flush) begin
                            state_next    = FLUSH;
                            fifo_rst_next = 1'b0;
                            count_next    = '0;
                        end
                    end else begin
                        // Rejected requests leave thresholds and FIFO untouched.
                        err_next = 1'b1;
                    end
                end
            end
            SETTLE: begin
                state_next = IDLE;
                ready_next = 1'b1;
            end
            default: begin
                state_next = INIT_RST;
                count_next = '0;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= INIT_RST;
            count_reg    <= '0;
            full_reg     <= P'(DEF_ALM_FULL);
            empty_reg    <= P'(DEF_ALM_EMPTY);
            fifo_rst_reg <= 1'b0;
            ready_reg    <= 1'b0;
            err_reg      <= 1'b0;
            busy_reg     <= 1'b1;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            full_reg     <= full_next;
            empty_reg    <= empty_next;
            fifo_rst_reg <= fifo_rst_next;
            ready_reg    <= ready_next;
            err_reg      <= err_next;
            busy_reg     <= busy_next;
        end
    end

    assign cfg_ready        = ready_reg;
    assign cfg_err          = err_reg;
    assign busy             = busy_reg;
    assign fifo_rst_n       = fifo_rst_reg;
    assign alm_full_thresh  = full_reg;
    assign alm_empty_thresh = empty_reg;

endmodule

// File: doc/amiq_fifo_ctrl_sequencer.md
# amiq_fifo_ctrl_sequencer

Initiator side of the FIFO control interface: drives the FIFO hard reset (`fifo_rst_n`) and the almost-full / almost-empty thresholds. It accepts configuration requests over a valid/ready handshake and validates them against the FIFO depth. It sequences a multi-cycle FIFO reset at power-up and on flush requests. It sits between the configuration/register layer and the FIFO control inputs.

## Interface
- `P`, 4: FIFO pointer width; FIFO depth is 2**P; threshold width is P.
- `RST_CYCLES`, 4: number of cycles `fifo_rst_n` is held low per reset sequence; must be ≥ 1.
- `DEF_ALM_FULL`, 1: `alm_full_thresh` value after reset.
- `DEF_ALM_EMPTY`, 1: `alm_empty_thresh` value after reset.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `cfg_valid`  in  1  configuration request valid.
- `cfg_ready`  out  1  sequencer can accept a request.
- `cfg_flush`  in  1  request also performs a FIFO hard reset.
- `cfg_alm_full_thresh`  in  P  requested almost-full threshold.
- `cfg_alm_empty_thresh`  in  P  requested almost-empty threshold.
- `cfg_err`  out  1  one-cycle pulse: last accepted request was rejected.
- `busy`  out  1  sequencer not in IDLE.
- `fifo_rst_n`  out  1  FIFO hard reset, active-low.
- `alm_full_thresh`  out  P  threshold driven to FIFO.
- `alm_empty_thresh`  out  P  threshold driven to FIFO.

## Operation
- All outputs are registered.
- Values while `rst_n`=0:
  - `fifo_rst_n`=0, `cfg_ready`=0, `busy`=1, `cfg_err`=0.
  - `alm_full_thresh`=`DEF_ALM_FULL`, `alm_empty_thresh`=`DEF_ALM_EMPTY`.
  - state=INIT_RST, counter=0.
- States:
  - INIT_RST: `fifo_rst_n` low; counter increments each cycle. At the edge where counter==RST_CYCLES-1, go to IDLE, `fifo_rst_n`→1, `cfg_ready`→1.
  - IDLE: `cfg_ready`=1, `busy`=0. A transfer occurs on the edge where `cfg_valid`&&`cfg_ready`. Inputs are sampled only on a transfer.
  - FLUSH: `fifo_rst_n` low for RST_CYCLES cycles (same counter rule as INIT_RST), then go to SETTLE.
  - SETTLE: exactly one cycle with `cfg_ready`=0, then IDLE.
- Validity rule (sum computed in P+1 bits, no overflow): a request is valid iff
  - full≠0, and
  - empty≠0, and
  - full+empty ≤ 2**P.
- Valid request with `cfg_flush`=0: thresholds load at the accept edge; go to SETTLE.
- Valid request with `cfg_flush`=1: thresholds load and `fifo_rst_n`→0 at the accept edge; go to FLUSH.
- Invalid request:
  - Thresholds and `fifo_rst_n` are unchanged and no flush occurs, even if `cfg_flush`=1.
  - Go to SETTLE with `cfg_err`=1 during the SETTLE cycle only.
- Thresholds change only on a valid accept edge or on reset. They are stable throughout FLUSH.
- `busy` = (state≠IDLE).
- `rst_n` low in any state forces the reset values on the next edge. An in-progress flush or settle is abandoned, and the full INIT_RST sequence restarts.

## Timing
- Reset release: with `rst_n` sampled high at edge E0, `fifo_rst_n` is low through edges E0..E(RST_CYCLES-1). It rises after edge E(RST_CYCLES-1), together with `cfg_ready`.
- Accept at edge A:
  - Non-flush: new thresholds visible after A; `cfg_ready` low for one cycle; next accept possible at A+2.
  - Flush: `fifo_rst_n` low after A through edge A+RST_CYCLES-1; high after A+RST_CYCLES; `cfg_ready` returns high after A+RST_CYCLES+1.
- Maximum throughput: one request per 2 cycles (non-flush).
- `cfg_valid` may be held high; a request is consumed once per transfer.

## Test plan
Conditions: P=4, RST_CYCLES=4, defaults 1/1.
- Reset release → `fifo_rst_n`=0 for exactly 4 cycles, then 1; `cfg_ready` rises the same cycle; thresholds read 1/1.
- Non-flush request full=3, empty=2 → thresholds 3/2 one cycle after accept; `cfg_ready` low 1 cycle; `fifo_rst_n` stays 1; `cfg_err`=0.
- Flush request full=8, empty=8 (sum=16, boundary-valid) → thresholds 8/8; `fifo_rst_n` low exactly 4 cycles; `cfg_ready` high again 5 cycles after accept.
- Invalid requests (full=0; full=9 empty=8 giving sum 17; flush=1 with empty=0) → `cfg_err` pulses 1 cycle each; thresholds unchanged; `fifo_rst_n` never drops.
- `rst_n` driven low in the 2nd FLUSH cycle → thresholds return to 1/1; the full 4-cycle INIT_RST reruns after release.
- `cfg_valid` held high with changing data → exactly one accept per 2 cycles; each accepted value appears in order.
